// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle for mem_port_arbiter: fetch and data requesters plus the shared memory port.
// slave is the arbiter's view; master is the requesters-and-memory side.
interface mem_port_arbiter_if;
  logic        f_req;
  logic [63:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] rdata;
  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    output f_gnt, f_rvalid, d_gnt, d_rvalid, rdata, m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    input  f_gnt, f_rvalid, d_gnt, d_rvalid, rdata, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage, one transaction at a time.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STARVE_LIMIT back-to-back data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic               clock,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_idle;
  logic        w_pick_f;
  logic        w_pick_d;
  logic        w_starved;
  logic [63:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_f_gnt;
  logic        r_d_gnt;
  logic        r_f_rvalid;
  logic        r_d_rvalid;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must lie in 1..15");
  end

  assign w_idle   = (r_state == IDLE);
  assign w_pick_f = w_idle && bus.f_req && (!bus.d_req || w_starved);
  assign w_pick_d = w_idle && bus.d_req && !w_pick_f;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  assign w_starved = (r_starve_cnt == 4'(STARVE_LIMIT));

  // Counts data wins that overtook a waiting fetch; any gap in f_req forgives the history.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (!bus.f_req || w_pick_f) begin
        r_starve_cnt <= '0;
      end else if (w_pick_d && r_starve_cnt != 4'hF) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  assign w_starved = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_f) begin
          w_next_state = BUSY_F;
        end else if (w_pick_d) begin
          w_next_state = BUSY_D;
        end
      end
      BUSY_F, BUSY_D: begin
        if (bus.m_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Winner's request is captured at the grant edge so the memory port stays frozen while BUSY.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_f_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_f_gnt    <= w_pick_f;
      r_d_gnt    <= w_pick_d;
      r_f_rvalid <= (r_state == BUSY_F) && bus.m_ready;
      r_d_rvalid <= (r_state == BUSY_D) && bus.m_ready;
      if (w_pick_f) begin
        r_addr <= bus.f_addr;
        r_we   <= 1'b0;
      end else if (w_pick_d) begin
        r_addr  <= bus.d_addr;
        r_we    <= bus.d_we;
        r_wdata <= bus.d_wdata;
      end
      if (!w_idle && bus.m_ready && !r_we) begin
        r_rdata <= bus.m_rdata;
      end
    end
  end

  assign bus.f_gnt    = r_f_gnt;
  assign bus.d_gnt    = r_d_gnt;
  assign bus.f_rvalid = r_f_rvalid;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.rdata    = r_rdata;
  assign bus.m_req    = !w_idle;
  assign bus.m_we     = r_we;
  assign bus.m_addr   = r_addr & ~64'h3;
  assign bus.m_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by randomized two-requester traffic.
// A transaction-level reference model predicts grants and completions; a monitor checks them.
module tb_mem_port_arbiter;

  localparam int StarveLimit = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GuardOn = 1'b1;
`else
  localparam bit GuardOn = 1'b0;
`endif

  typedef struct {
    logic [1:0]  who;
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0]  who;
    logic        we;
    logic [63:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clock = 1'b0;
  logic rst_n;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(.STARVE_LIMIT(StarveLimit)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  exp_t        expGnt[$];
  exp_t        expRv[$];
  txn_t        cur;
  bit          mBusy = 1'b0;
  int          fetchWaitWins = 0;
  logic [31:0] lastRdata = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fReq, input logic [63:0] fAddr, input logic dReq,
                               input logic dWe, input logic [63:0] dAddr, input logic [31:0] dWdata);
    bus.f_req   = fReq;
    bus.f_addr  = fAddr;
    bus.d_req   = dReq;
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
  endtask

  task automatic issueFetch();
    bus.f_req  = 1'b1;
    bus.f_addr = {$urandom, $urandom};
  endtask

  task automatic issueData();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = {$urandom, $urandom};
    bus.d_wdata = $urandom;
  endtask

  // Reference model: one transaction owns the port from grant to completion; arbitration happens only when free.
  initial begin : refModel
    bit fetchWins;
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) begin
        mBusy         = 1'b0;
        fetchWaitWins = 0;
        lastRdata     = '0;
      end else begin
        cyc++;
        if (mBusy) begin
          if (bus.m_ready) begin
            if (!cur.we) lastRdata = bus.m_rdata;
            expRv.push_back('{who: cur.who, cyc: cyc, rdata: lastRdata});
            mBusy = 1'b0;
          end
        end else begin
          fetchWins = bus.f_req && (!bus.d_req || (GuardOn && fetchWaitWins == StarveLimit));
          if (fetchWins) begin
            cur = '{who: 2'b10, we: 1'b0, addr: bus.f_addr & ~64'h3, wdata: '0};
            fetchWaitWins = 0;
          end else if (bus.d_req) begin
            cur = '{who: 2'b01, we: bus.d_we, addr: bus.d_addr & ~64'h3, wdata: bus.d_wdata};
            if (bus.f_req) fetchWaitWins++;
          end
          if (!bus.f_req) fetchWaitWins = 0;
          if (fetchWins || bus.d_req) begin
            expGnt.push_back('{who: cur.who, cyc: cyc, rdata: '0});
            mBusy = 1'b1;
          end
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (rst_n === 1'b1) begin
        if (bus.f_gnt || bus.d_gnt) begin
          if (expGnt.size() == 0) begin
            checkOutput("gntUnexpected", {bus.f_gnt, bus.d_gnt}, 0);
          end else begin
            e = expGnt.pop_front();
            checkOutput("gntWho", {bus.f_gnt, bus.d_gnt}, e.who);
            checkOutput("gntCycle", cyc, e.cyc);
          end
        end
        if (bus.f_rvalid || bus.d_rvalid) begin
          if (expRv.size() == 0) begin
            checkOutput("rvalidUnexpected", {bus.f_rvalid, bus.d_rvalid}, 0);
          end else begin
            e = expRv.pop_front();
            checkOutput("rvalidWho", {bus.f_rvalid, bus.d_rvalid}, e.who);
            checkOutput("rvalidCycle", cyc, e.cyc);
            checkOutput("rdata", bus.rdata, e.rdata);
          end
        end
        checkOutput("mReq", bus.m_req, mBusy);
        if (mBusy) begin
          checkOutput("mAddr", bus.m_addr, cur.addr);
          checkOutput("mWe", bus.m_we, cur.we);
          if (cur.we) checkOutput("mWdata", bus.m_wdata, cur.wdata);
        end
      end
    end
  end

  initial begin : main
    int dGrants;
    bit fGranted;
    int fState;
    int dState;

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    repeat (2) @(negedge clock);
    checkOutput("rstMReq", bus.m_req, 0);
    checkOutput("rstMWe", bus.m_we, 0);
    checkOutput("rstMAddr", bus.m_addr, 0);
    checkOutput("rstMWdata", bus.m_wdata, 0);
    checkOutput("rstRdata", bus.rdata, 0);
    checkOutput("rstGnts", {bus.f_gnt, bus.d_gnt}, 0);
    checkOutput("rstRvalids", {bus.f_rvalid, bus.d_rvalid}, 0);
    rst_n = 1'b1;
    @(negedge clock);
    checkOutput("idleNoReq", bus.m_req, 0);

    // Single load, zero wait states
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 64'h10, '0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h4;
    @(negedge clock);
    checkOutput("loadGnt", bus.d_gnt, 1);
    checkOutput("loadMAddr", bus.m_addr, 64'h10);
    bus.d_req = 1'b0;
    @(negedge clock);
    checkOutput("loadRvalid", bus.d_rvalid, 1);
    checkOutput("loadRdata", bus.rdata, 32'h4);

    // Collision: data first, fetch after one idle cycle
    @(negedge clock);
    applyStimulus(1'b1, 64'h100, 1'b1, 1'b0, 64'h200, '0);
    bus.m_rdata = 32'h33;
    @(negedge clock);
    checkOutput("collDGnt", {bus.f_gnt, bus.d_gnt}, 2'b01);
    bus.d_req = 1'b0;
    @(negedge clock);
    checkOutput("collDRvalid", bus.d_rvalid, 1);
    checkOutput("collIdleGap", bus.f_gnt, 0);
    @(negedge clock);
    checkOutput("collFGnt", bus.f_gnt, 1);
    bus.f_req = 1'b0;
    @(negedge clock);
    checkOutput("collFRvalid", bus.f_rvalid, 1);

    // Store with four wait states; rdata must keep the previous load value
    @(negedge clock);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 64'h0C, 32'h1E);
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      if (i == 1) begin
        checkOutput("storeGnt", bus.d_gnt, 1);
        bus.d_req = 1'b0;
      end
      checkOutput("storeMReq", bus.m_req, 1);
      checkOutput("storeMWe", bus.m_we, 1);
      checkOutput("storeMAddr", bus.m_addr, 64'h0C);
      checkOutput("storeMWdata", bus.m_wdata, 32'h1E);
      bus.m_ready = (i == 5);
    end
    @(negedge clock);
    checkOutput("storeRvalid", bus.d_rvalid, 1);
    checkOutput("storeRdataKept", bus.rdata, 32'h33);
    bus.m_ready = 1'b0;
    @(negedge clock);
    checkOutput("storeRvalidPulse", bus.d_rvalid, 0);

    // Misaligned fetch address is word aligned on the port
    applyStimulus(1'b1, 64'h7, 1'b0, 1'b0, '0, '0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'hABCD;
    @(negedge clock);
    checkOutput("misFGnt", bus.f_gnt, 1);
    checkOutput("misMAddr", bus.m_addr, 64'h4);
    bus.f_req = 1'b0;
    @(negedge clock);
    checkOutput("misRdata", bus.rdata, 32'hABCD);

    // Fetch held against a continuous data stream
    @(negedge clock);
    applyStimulus(1'b1, 64'h400, 1'b1, 1'b0, 64'h300, '0);
    dGrants  = 0;
    fGranted = 1'b0;
    for (int c = 0; c < 40 && !fGranted; c++) begin
      @(negedge clock);
      bus.m_rdata = $urandom;
      if (bus.d_gnt) dGrants++;
      if (bus.f_gnt) fGranted = 1'b1;
    end
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("starveDataGrants", dGrants, StarveLimit);
    checkOutput("starveFetchGranted", fGranted, 1);
`else
    checkOutput("fixedPrioFetchBlocked", fGranted, 0);
    checkOutput("fixedPrioDataGrants", (dGrants >= 10), 1);
`endif
    bus.f_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (4) @(negedge clock);

    // Reset during a stalled fetch discards it; a pending fetch is granted right after release
    applyStimulus(1'b1, 64'h40, 1'b0, 1'b0, '0, '0);
    bus.m_ready = 1'b0;
    @(negedge clock);
    checkOutput("rstFlightGnt", bus.f_gnt, 1);
    bus.f_req = 1'b0;
    @(negedge clock);
    checkOutput("rstFlightBusy", bus.m_req, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstAsyncMReq", bus.m_req, 0);
    checkOutput("rstAsyncMAddr", bus.m_addr, 0);
    bus.f_req   = 1'b1;
    bus.f_addr  = 64'h80;
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h77;
    @(negedge clock);
    checkOutput("rstNoRvalid", bus.f_rvalid, 0);
    rst_n = 1'b1;
    @(negedge clock);
    checkOutput("postRstFGnt", bus.f_gnt, 1);
    checkOutput("postRstNoStaleRvalid", bus.f_rvalid, 0);
    checkOutput("postRstMAddr", bus.m_addr, 64'h80);
    bus.f_req = 1'b0;
    @(negedge clock);
    checkOutput("postRstFRvalid", bus.f_rvalid, 1);
    checkOutput("postRstRdata", bus.rdata, 32'h77);

    // Randomized traffic; memory stalls at random and m_ready also toggles while idle
    fState = 0;
    dState = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      bus.m_ready = ($urandom_range(0, 2) == 0);
      bus.m_rdata = $urandom;
      case (fState)
        0: if (c < 2000 && $urandom_range(0, 3) == 0) begin issueFetch(); fState = 1; end
        1: if (bus.f_gnt) begin bus.f_req = 1'b0; fState = 2; end
        default: if (bus.f_rvalid) fState = 0;
      endcase
      case (dState)
        0: if (c < 2000 && $urandom_range(0, 2) == 0) begin issueData(); dState = 1; end
        1: if (bus.d_gnt) begin bus.d_req = 1'b0; dState = 2; end
        default: begin
          if (bus.d_rvalid) begin
            if (c < 2000 && $urandom_range(0, 1) == 1) begin
              issueData();
              dState = 1;
            end else begin
              dState = 0;
            end
          end
        end
      endcase
      if (c >= 2000 && fState == 0 && dState == 0) break;
    end
    checkOutput("trafficDrained", (fState == 0 && dState == 0), 1);
    repeat (3) @(negedge clock);
    checkOutput("gntQueueEmpty", expGnt.size(), 0);
    checkOutput("rvalidQueueEmpty", expRv.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, is the number of consecutive data grants allowed while fetch waits (legal 1..15, 4-bit counter).
REQ-002 Port: clock  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: f_req  input  1  fetch-stage read request; held until f_gnt.
REQ-005 Port: f_addr  input  64  fetch byte address (PC).
REQ-006 Port: f_gnt  output  1  one-cycle pulse; fetch request accepted and latched.
REQ-007 Port: f_rvalid  output  1  one-cycle pulse; rdata holds the fetched instruction.
REQ-008 Port: d_req  input  1  MEM-stage request (LD/SD); held until d_gnt.
REQ-009 Port: d_we  input  1  1 = store (SD), 0 = load (LD).
REQ-010 Port: d_addr  input  64  data byte address (EXMEMALUOut).
REQ-011 Port: d_wdata  input  32  store data (EXMEMB low word).
REQ-012 Port: d_gnt  output  1  one-cycle pulse; data request accepted and latched.
REQ-013 Port: d_rvalid  output  1  one-cycle pulse; load data in rdata, or store complete.
REQ-014 Port: rdata  output  32  read data returned to the granted requester.
REQ-015 Port: m_req  output  1  memory port request; high for the whole transaction.
REQ-016 Port: m_we  output  1  memory write enable.
REQ-017 Port: m_addr  output  64  word-aligned address: {latched_addr[63:2], 2'b00}.
REQ-018 Port: m_wdata  output  32  latched store data.
REQ-019 Port: m_ready  input  1  memory completes the current access this cycle; m_rdata valid.
REQ-020 Port: m_rdata  input  32  memory read data.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY_F, BUSY_D.
REQ-022 In IDLE at posedge with any request, it SHALL pick a winner: d_req wins unless the starvation condition (REQ-030) holds and f_req is high, in which case fetch wins.
REQ-023 On a win it SHALL latch the winner's addr/we/wdata (fetch: we=0), enter BUSY_F/BUSY_D, and pulse the matching gnt for the first BUSY cycle only.
REQ-024 m_req SHALL be high exactly while in BUSY_x, decoded from registered state; m_addr/m_we/m_wdata SHALL come from latched copies and stay stable throughout BUSY.
REQ-025 In BUSY_x, m_ready=1 at posedge SHALL register rdata<=m_rdata for loads/fetches (unchanged for stores), pulse x_rvalid one cycle, and return to IDLE.
REQ-026 m_ready SHALL be ignored in IDLE; wait states in BUSY are unbounded.
REQ-027 Minimum latency: req sampled at edge 0 -> gnt in cycle 1 -> rvalid in cycle 2 when m_ready=1 in cycle 1; one IDLE cycle SHALL separate consecutive transactions.
REQ-028 Requests arriving or dropping during BUSY SHALL NOT affect the current transaction; the losing request stays pending.
REQ-029 With both requests low, the FSM SHALL stay in IDLE with m_req=0.
REQ-030 Starvation condition: starve_cnt == STARVE_LIMIT; starve_cnt SHALL increment (saturating) on each data grant while f_req=1, and clear on any fetch grant or whenever f_req=0 in IDLE.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, starve_cnt=0, and f_gnt, d_gnt, f_rvalid, d_rvalid, m_req, m_we = 0, m_addr=0, m_wdata=0, rdata=0.
REQ-032 A transaction in flight at reset SHALL be discarded with no rvalid; after rst_n rises, arbitration restarts at the first posedge.

Configuration
REQ-033 Macro ARB_STARVE_GUARD_EN defined: starvation counter and REQ-030 are active.
REQ-034 ARB_STARVE_GUARD_EN undefined: no counter is built and d_req always wins (fixed data priority); all other behaviour is identical.

Verification
REQ-035 Single load: d_req=1, d_we=0, d_addr=0x10, m_ready=1 with m_rdata=0x4 -> d_gnt in cycle 1; m_addr=0x10; d_rvalid and rdata=0x4 in cycle 2.
REQ-036 Collision: f_req and d_req both rise in the same cycle -> d_gnt first; f_gnt after d_rvalid plus one IDLE cycle.
REQ-037 Starvation with guard and STARVE_LIMIT=3: f_req held, d_req held continuously -> exactly 3 data grants, then f_gnt; without the macro, f_gnt never occurs while d_req stays high.
REQ-038 Store with waits: d_we=1, d_addr=0x0C, d_wdata=0x1E, m_ready low for 4 cycles -> m_req, m_we, m_addr=0x0C, m_wdata=0x1E stable for 5 cycles; d_rvalid one cycle; rdata unchanged.
REQ-039 Misaligned fetch: f_addr=0x7 -> m_addr=0x4.
REQ-040 Reset mid-transaction: rst_n low during BUSY_F -> m_req drops asynchronously; no f_rvalid; fetch pending after reset is granted in cycle 1.
